// File: rtl/riscv_defs.sv
// Shared definitions for the instruction memory: NOP encoding, loader
// state encoding and a little-endian byte placement helper.
package riscv_defs;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    LOAD_HDR  = 2'd0,
    LOAD_DATA = 2'd1,
    LOAD_RUN  = 2'd2
  } load_state_e;

  // Drop one loader byte into its little-endian lane of a 32-bit word.
  function automatic logic [31:0] place_byte(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  data);
    logic [31:0] res;
    // NOTE: combinational code (functions, always_comb) uses blocking '=';
    // only always_ff state updates use non-blocking '<='.
    res = word;
    case (lane)
      2'd0:    res[7:0]   = data;
      2'd1:    res[15:8]  = data;
      2'd2:    res[23:16] = data;
      default: res[31:24] = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/inst_mem_if.sv
// Fetch and boot-loader signal bundle between the SoC side and inst_mem.
interface inst_mem_if;
  logic [31:0] inst_addr_i;   // fetch byte address from the core
  logic [31:0] inst_o;        // fetched instruction
  logic        load_valid_i;  // loader byte valid
  logic [7:0]  load_data_i;   // loader byte
  logic        load_ready_o;  // byte accepted this cycle when valid
  logic        load_done_o;   // image loaded, core running
  logic        load_err_o;    // sticky: header count exceeded depth
  logic        core_hold_o;   // hold the core in reset

  // SoC side: core fetch plus boot loader.
  modport master (
    output inst_addr_i, load_valid_i, load_data_i,
    input  inst_o, load_ready_o, load_done_o, load_err_o, core_hold_o
  );

  // Memory side.
  modport slave (
    input  inst_addr_i, load_valid_i, load_data_i,
    output inst_o, load_ready_o, load_done_o, load_err_o, core_hold_o
  );
endinterface

// File: rtl/inst_ram_array.sv
// Word storage with one write port and one registered read port.
module inst_ram_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Store a completed loader word and register the addressed word each cycle.
  // NOTE: the storage deliberately has no reset so it maps onto block RAM;
  // contents survive a reset and are only replaced by a later load.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_mem.sv
// Boot-loaded instruction memory: byte-stream loader FSM, word assembler,
// fetch range check and NOP substitution around a registered-read RAM.
module inst_mem
  import riscv_defs::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic      clk,
  input  logic      rst,
  inst_mem_if.slave bus
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_W32 = 32'(DEPTH_WORDS);

  load_state_e state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;   // byte lane within the current word
  logic [31:0] asm_q, asm_d;             // header / data word being assembled
  logic [31:0] word_cnt_q, word_cnt_d;   // N from the header
  logic [31:0] word_idx_q, word_idx_d;   // next data word number, never wraps
  logic        err_q, err_d;
  logic        rd_valid_q, rd_valid_d;   // registered read is an in-range RUN fetch

  logic          accept;
  logic          word_full;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [AW-1:0] ram_raddr;
  logic [31:0]   ram_rdata;

  logic [32:0] addr_diff;       // bit 32 is the borrow of addr - BASE_ADDR
  logic [31:0] fetch_idx;
  logic        fetch_in_range;

  inst_ram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (asm_d),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Translate the fetch byte address into a word index and range-check it.
  always_comb begin
    addr_diff      = {1'b0, bus.inst_addr_i} - {1'b0, BASE_ADDR};
    fetch_idx      = addr_diff[31:0] >> 2;
    fetch_in_range = !addr_diff[32] && (fetch_idx < DEPTH_W32);
    ram_raddr      = fetch_idx[AW-1:0];
  end

  // Next-state and datapath: assemble bytes, decode header, write data words.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    word_cnt_d = word_cnt_q;
    word_idx_d = word_idx_q;
    err_d      = err_q;
    ram_we     = 1'b0;
    ram_waddr  = word_idx_q[AW-1:0];

    accept    = bus.load_valid_i && (state_q != LOAD_RUN);
    word_full = accept && (byte_cnt_q == 2'd3);

    if (accept) begin
      asm_d      = place_byte(asm_q, byte_cnt_q, bus.load_data_i);
      byte_cnt_d = byte_cnt_q + 2'd1;
    end

    case (state_q)
      LOAD_HDR: begin
        if (word_full) begin
          word_cnt_d = asm_d;
          word_idx_d = '0;
          byte_cnt_d = '0;
          if (asm_d > DEPTH_W32) begin
            err_d = 1'b1;
          end
          state_d = (asm_d == 32'd0) ? LOAD_RUN : LOAD_DATA;
        end
      end
      LOAD_DATA: begin
        if (word_full) begin
          // Words past the end of the array are consumed but not stored.
          ram_we     = (word_idx_q < DEPTH_W32);
          word_idx_d = word_idx_q + 32'd1;
          if (word_idx_q == word_cnt_q - 32'd1) begin
            state_d = LOAD_RUN;
          end
        end
      end
      default: ;
    endcase

    // The read registered on the edge entering RUN already counts as a fetch.
    rd_valid_d = (state_d == LOAD_RUN) && fetch_in_range;
  end

  // State register and datapath flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD_HDR;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      word_cnt_q <= '0;
      word_idx_q <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      word_cnt_q <= word_cnt_d;
      word_idx_q <= word_idx_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Outputs decoded from the state register; fetch data falls back to NOP.
  always_comb begin
    bus.load_ready_o = (state_q != LOAD_RUN);
    bus.load_done_o  = (state_q == LOAD_RUN);
    bus.core_hold_o  = (state_q != LOAD_RUN);
    bus.load_err_o   = err_q;
    bus.inst_o       = rd_valid_q ? ram_rdata : NOP_INST;
  end

endmodule

// File: tb/tb_inst_mem.sv
// Scoreboard bench for inst_mem: three instances (default, depth 4,
// base 0x100) driven with directed loader images and fetches.
module tb_inst_mem;
  import riscv_defs::*;

  typedef enum int {S_INST, S_READY, S_DONE, S_ERR, S_HOLD} sig_e;

  typedef struct {
    int          due;
    int          dut;
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] addr  [3];
  logic        lv    [3];
  logic [7:0]  ld    [3];
  logic [31:0] o_inst[3];
  logic        o_ready[3], o_done[3], o_err[3], o_hold[3];

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [31:0] mon_act;
  logic [7:0] img[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  inst_mem_if if0();
  inst_mem_if if1();
  inst_mem_if if2();

  assign if0.inst_addr_i  = addr[0];
  assign if0.load_valid_i = lv[0];
  assign if0.load_data_i  = ld[0];
  assign o_inst[0]  = if0.inst_o;
  assign o_ready[0] = if0.load_ready_o;
  assign o_done[0]  = if0.load_done_o;
  assign o_err[0]   = if0.load_err_o;
  assign o_hold[0]  = if0.core_hold_o;

  assign if1.inst_addr_i  = addr[1];
  assign if1.load_valid_i = lv[1];
  assign if1.load_data_i  = ld[1];
  assign o_inst[1]  = if1.inst_o;
  assign o_ready[1] = if1.load_ready_o;
  assign o_done[1]  = if1.load_done_o;
  assign o_err[1]   = if1.load_err_o;
  assign o_hold[1]  = if1.core_hold_o;

  assign if2.inst_addr_i  = addr[2];
  assign if2.load_valid_i = lv[2];
  assign if2.load_data_i  = ld[2];
  assign o_inst[2]  = if2.inst_o;
  assign o_ready[2] = if2.load_ready_o;
  assign o_done[2]  = if2.load_done_o;
  assign o_err[2]   = if2.load_err_o;
  assign o_hold[2]  = if2.core_hold_o;

  inst_mem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000)) u_def (
    .clk (clk), .rst (rst), .bus (if0));
  inst_mem #(.DEPTH_WORDS(4), .BASE_ADDR(32'h0000_0000)) u_small (
    .clk (clk), .rst (rst), .bus (if1));
  inst_mem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0100)) u_base (
    .clk (clk), .rst (rst), .bus (if2));

  function automatic logic [31:0] get_act(input int d, input sig_e s);
    case (s)
      S_INST:  return o_inst[d];
      S_READY: return {31'd0, o_ready[d]};
      S_DONE:  return {31'd0, o_done[d]};
      S_ERR:   return {31'd0, o_err[d]};
      default: return {31'd0, o_hold[d]};
    endcase
  endfunction

  // Push an expectation due 'delay' cycles from now (checked at that negedge).
  task automatic expect_at(input int d, input sig_e s, input logic [31:0] v,
                           input string nm, input int delay);
    exp_t e;
    e.due  = cyc + delay;
    e.dut  = d;
    e.sig  = s;
    e.val  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every expectation whose cycle has come up.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      mon_e   = exp_q.pop_front();
      mon_act = get_act(mon_e.dut, mon_e.sig);
      n_tests++;
      if (mon_act !== mon_e.val) begin
        n_fail++;
        $display("FAIL %s (dut%0d cyc %0d): got %h expected %h",
                 mon_e.name, mon_e.dut, cyc, mon_act, mon_e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // Offer one byte, wait (bounded) for ready, optionally idle a cycle after.
  task automatic send_byte(input int d, input logic [7:0] b, input bit gap);
    int waited;
    waited = 0;
    lv[d] = 1'b1;
    ld[d] = b;
    while (!o_ready[d] && waited < 20) begin
      tick();
      waited++;
    end
    n_tests++;
    if (!o_ready[d]) begin
      n_fail++;
      $display("FAIL send_byte dut%0d: load_ready_o got 0 expected 1 within 20 cycles", d);
      lv[d] = 1'b0;
      return;
    end
    tick();
    lv[d] = 1'b0;
    if (gap) tick();
  endtask

  // Stream img[] and check header error and the done edge on the last byte.
  task automatic load_img(input int d, input bit gap, input logic exp_err);
    int n;
    n = img.size();
    for (int i = 0; i < n; i++) begin
      send_byte(d, img[i], gap);
      if (i == 3) expect_at(d, S_ERR, {31'd0, exp_err}, "hdr_err", 0);
      if (i == n - 2) expect_at(d, S_DONE, 32'd0, "done_before_last", 0);
      if (i == n - 1) begin
        expect_at(d, S_DONE,  32'd1, "done_on_last", 0);
        expect_at(d, S_HOLD,  32'd0, "hold_released", 0);
        expect_at(d, S_READY, 32'd0, "ready_in_run", 0);
      end
    end
  endtask

  // Present an address; the instruction is expected one cycle later.
  task automatic fetch(input int d, input logic [31:0] a, input logic [31:0] v,
                       input string nm);
    addr[d] = a;
    expect_at(d, S_INST, v, nm, 1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      addr[d] = 32'd0;
      lv[d]   = 1'b0;
      ld[d]   = 8'd0;
    end
    addr[2] = 32'h100;

    // Reset values.
    do_reset(3);
    for (int d = 0; d < 3; d++) begin
      expect_at(d, S_INST,  NOP_INST, "rst_inst", 0);
      expect_at(d, S_READY, 32'd1,    "rst_ready", 0);
      expect_at(d, S_HOLD,  32'd1,    "rst_hold", 0);
      expect_at(d, S_DONE,  32'd0,    "rst_done", 0);
      expect_at(d, S_ERR,   32'd0,    "rst_err", 0);
    end
    tick();
    expect_at(0, S_READY, 32'd1, "idle_ready", 0);
    tick();

    // Basic load and fetch on the default instance.
    img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
            8'h13, 8'h01, 8'h20, 8'h00};
    load_img(0, 1'b0, 1'b0);
    expect_at(0, S_INST, 32'h0010_0093, "first_run_read", 0);
    fetch(0, 32'h0000_0000, 32'h0010_0093, "fetch_0");
    fetch(0, 32'h0000_0004, 32'h0020_0113, "fetch_4");
    fetch(0, 32'h0000_0007, 32'h0020_0113, "fetch_7_lowbits");
    fetch(0, 32'h0000_1000, NOP_INST,      "fetch_past_depth");
    fetch(0, 32'h0000_0000, 32'h0010_0093, "fetch_0_again");

    // Same image with a gap after every byte, base 0x100 instance.
    load_img(2, 1'b1, 1'b0);
    expect_at(2, S_INST, 32'h0010_0093, "gap_first_read", 0);
    fetch(2, 32'h0000_00FC, NOP_INST,      "base_below");
    fetch(2, 32'h0000_0102, 32'h0010_0093, "base_0x102");
    fetch(2, 32'h0000_0104, 32'h0020_0113, "base_0x104");
    fetch(2, 32'h0000_0000, NOP_INST,      "base_zero");
    fetch(2, 32'h0000_1100, NOP_INST,      "base_past_depth");
    fetch(2, 32'hFFFF_FFFC, NOP_INST,      "base_top");

    // Oversize image on the depth-4 instance: N = 6, bytes 0x10..0x27.
    addr[1] = 32'd0;
    img = '{8'h06, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 24; i++) img.push_back(8'(8'h10 + i));
    load_img(1, 1'b0, 1'b1);
    expect_at(1, S_ERR, 32'd1, "oversize_err_sticky", 0);
    fetch(1, 32'h0000_0000, 32'h1312_1110, "ovs_w0");
    fetch(1, 32'h0000_0004, 32'h1716_1514, "ovs_w1");
    fetch(1, 32'h0000_0008, 32'h1B1A_1918, "ovs_w2");
    fetch(1, 32'h0000_000C, 32'h1F1E_1D1C, "ovs_w3");
    fetch(1, 32'h0000_0010, NOP_INST,      "ovs_0x10");

    // Empty image: RUN after the header, old contents still readable.
    addr[0] = 32'd0;
    do_reset(1);
    expect_at(0, S_HOLD, 32'd1, "reload_hold", 0);
    expect_at(0, S_INST, NOP_INST, "reload_inst_nop", 0);
    img = '{8'h00, 8'h00, 8'h00, 8'h00};
    load_img(0, 1'b0, 1'b0);
    fetch(0, 32'h0000_0000, 32'h0010_0093, "empty_keeps_w0");
    fetch(0, 32'h0000_0004, 32'h0020_0113, "empty_keeps_w1");

    // Reset after two data bytes, then a one-word reload.
    addr[0] = 32'd0;
    do_reset(1);
    img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
    for (int i = 0; i < 6; i++) send_byte(0, img[i], 1'b0);
    expect_at(0, S_DONE, 32'd0, "midload_done", 0);
    do_reset(1);
    expect_at(0, S_READY, 32'd1, "midrst_ready", 0);
    expect_at(0, S_HOLD,  32'd1, "midrst_hold", 0);
    expect_at(0, S_DONE,  32'd0, "midrst_done", 0);
    img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load_img(0, 1'b0, 1'b0);
    fetch(0, 32'h0000_0000, 32'hDEAD_BEEF, "reload_w0");
    fetch(0, 32'h0000_0004, 32'h0020_0113, "reload_keeps_w1");

    // Reset in RUN holds the core again on the next edge.
    rst = 1'b1;
    tick();
    expect_at(0, S_HOLD,  32'd1,    "runrst_hold", 0);
    expect_at(0, S_DONE,  32'd0,    "runrst_done", 0);
    expect_at(0, S_READY, 32'd1,    "runrst_ready", 0);
    expect_at(0, S_INST,  NOP_INST, "runrst_inst", 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
